mux8_scanner: RTL and testbench
===============================

# mux8_scanner

Sequencer that sits directly upstream of the 8:1 mux `mux8`. It drives the mux select lines through all eight inputs and samples the mux output `y` after a programmable settle time. It assembles the eight samples into one byte and presents that byte on a valid/ready output port. It turns the combinational mux into a start-triggered 8-bit parallel capture.

## Interface
- `SETTLE`, default 2: number of cycles each select value is held before `y` is sampled; legal range 1..15.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: request one scan; sampled only as defined below.
- `y  in  1`: output of `mux8`.
- `s0  out  1`: select bit 0 (LSB of the select index), wired to `mux8` s0.
- `s1  out  1`: select bit 1, wired to `mux8` s1.
- `s2  out  1`: select bit 2 (MSB), wired to `mux8` s2.
- `busy  out  1`: high while a scan is in progress.
- `data  out  8`: captured word; `data[i]` is the value of `y` sampled with select index i.
- `valid  out  1`: `data` holds a new word not yet consumed.
- `ready  in  1`: consumer accepts `data` when `valid && ready` at a rising edge.

## Operation
- FSM with three states:
  - IDLE: select = 3'b000, `busy`=0, `valid`=0.
  - SCAN: `busy`=1, `valid`=0.
  - HOLD: `busy`=0, `valid`=1.
- Internal registers:
  - `idx[2:0]` drives {s2,s1,s0} directly from a register (glitch-free).
  - `cnt` is the settle counter.
  - `shreg[7:0]` is the capture register.
- IDLE -> SCAN when `start`=1: `idx`←0, `cnt`←0. In IDLE and SCAN, `start` is otherwise ignored.
- SCAN, each cycle:
  - If `cnt` != SETTLE-1: `cnt`←`cnt`+1.
  - Else: `shreg[idx]`←`y`, `cnt`←0.
    - If `idx` != 7: `idx`←`idx`+1.
    - If `idx` == 7: `data`←{`y`,`shreg[6:0]`}, `idx`←0, go to HOLD.
- HOLD:
  - `data` and `valid` are held stable until `valid && ready`.
  - On handshake, if `start`=1 in the same cycle: go directly to SCAN (`idx`←0, `cnt`←0), no idle bubble.
  - On handshake with `start`=0: go to IDLE.
- `data` changes only on the SCAN->HOLD transition. During a scan it keeps the previous word.
- `ready` is ignored outside HOLD.
- Reset asserted at any time, including mid-scan or in HOLD, immediately clears all state. The partial scan is discarded.
- Reset values:
  - s2,s1,s0 = 000
  - `busy`=0, `valid`=0
  - `data`=8'h00
  - internal `shreg`=0, `cnt`=0, state IDLE

## Timing
- Start accepted at edge E0 → `busy`=1 and select=0 after E0.
- Select index i is driven during cycles after edges E0+i·SETTLE through E0+(i+1)·SETTLE.
- `y` for index i is sampled at edge E0+(i+1)·SETTLE. `y` must be stable SETTLE cycles after a select change.
- At edge E0+8·SETTLE: `valid`=1, `busy`=0, `data` updated. Latency from start to valid = 8·SETTLE cycles (16 at default).
- Handshake at edge H → `valid`=0 after H.
- Back-to-back scans (`start` with handshake) have a period of 8·SETTLE+1 cycles when `ready` is held high.
- SETTLE=1: select advances every cycle and one sample is taken per cycle.
- `valid` never deasserts without a handshake or reset.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → s=000, `busy`=0, `valid`=0, `data`=8'h00. Release with `start`=0 → stays IDLE.
- Single scan, SETTLE=2, behavioral `mux8` with a7=1 and the other inputs 0, `ready`=0:
  - select steps 0..7, two cycles each.
  - `valid` rises exactly 16 cycles after start, with `data`=8'h80.
  - `data` and `valid` stay stable for 5 cycles.
  - Then `ready`=1 for one cycle → `valid`=0, state IDLE.
- Pattern scan: inputs a0..a7 = 1,0,1,1,0,0,1,0 → `data`=8'h4D. `start` pulsed during SCAN is ignored, so exactly one `valid`.
- Back-to-back: `ready`=1 and `start`=1 held, inputs changed between scans (8'h4D then 8'hFF) → consecutive words 8'h4D, 8'hFF, with `valid` pulses 17 cycles apart.
- Reset mid-operation: assert `rst_n`=0 at idx=5 → all outputs take reset values immediately. After release, a new start gives a full 16-cycle scan and correct `data`.
- SETTLE=1 build: inputs 8'hA5 → `valid` 8 cycles after start, `data`=8'hA5.

Source files
------------

// File: rtl/mux8_scanner.sv
// mux8_scanner: start-triggered 8-bit parallel capture through an external
// 8:1 mux. Steps the mux select through indices 0..7, holds each for SETTLE
// cycles, samples y at the end of each hold and presents the assembled byte
// on a valid/ready port.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request one scan (honoured in IDLE, or in HOLD on handshake)
//   y        mux8 output
//   s0..s2   mux8 select lines, s2 is the MSB
//   busy     scan in progress
//   data     captured word, data[i] = y sampled with select index i
//   valid    data holds a word not yet consumed
//   ready    consumer accepts data when valid && ready
//
// state | meaning
// IDLE  | waiting for start, select parked at 000
// SCAN  | stepping the select and sampling y
// HOLD  | word presented, waiting for handshake

module mux8_scanner #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [7:0] shreg;

  // Select lines come straight from the idx register so they never glitch.
  assign s0 = idx[0];
  assign s1 = idx[1];
  assign s2 = idx[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
      cnt   <= 4'd0;
      shreg <= 8'h00;
      data  <= 8'h00;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            idx   <= 3'd0;
            cnt   <= 4'd0;
            busy  <= 1'b1;
          end
        end

        SCAN: begin
          if (cnt != SETTLE_LAST) begin
            cnt <= cnt + 4'd1;
          end else begin
            shreg[idx] <= y;
            cnt        <= 4'd0;
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
            end else begin
              // Last sample goes straight into data; shreg[7] is not yet
              // written at this edge.
              data  <= {y, shreg[6:0]};
              idx   <= 3'd0;
              state <= HOLD;
              busy  <= 1'b0;
              valid <= 1'b1;
            end
          end
        end

        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            if (start) begin
              state <= SCAN;
              idx   <= 3'd0;
              cnt   <= 4'd0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          idx   <= 3'd0;
          cnt   <= 4'd0;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_scanner.sv
// Testbench for mux8_scanner: one instance at SETTLE=2, one at SETTLE=1,
// each driving a behavioural mux8. Expected words and their arrival cycle
// are queued by the stimulus and checked by per-instance monitors.

module tb_mux8_scanner;

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;

  // SETTLE=2 instance
  logic       start2 = 1'b0, ready2 = 1'b0;
  logic [7:0] a2 = 8'h00;
  logic       y2, s0_2, s1_2, s2_2, busy2, valid2;
  logic [7:0] data2;
  logic [2:0] sel2;

  // SETTLE=1 instance
  logic       start1 = 1'b0, ready1 = 1'b0;
  logic [7:0] a1 = 8'h00;
  logic       y1, s0_1, s1_1, s2_1, busy1, valid1;
  logic [7:0] data1;

  int         total = 0;
  int         passed = 0;
  exp_t       q2[$];
  exp_t       q1[$];
  logic       vprev2 = 1'b0, vprev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sel2 = {s2_2, s1_2, s0_2};
  assign y2   = a2[sel2];
  assign y1   = a1[{s2_1, s1_1, s0_1}];

  mux8_scanner #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
    .s0(s0_2), .s1(s1_2), .s2(s2_2), .busy(busy2),
    .data(data2), .valid(valid2), .ready(ready2)
  );

  mux8_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
    .s0(s0_1), .s1(s1_1), .s2(s2_1), .busy(busy1),
    .data(data1), .valid(valid1), .ready(ready1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: a rising valid must match the head of the queue in both word
  // and arrival cycle.
  always @(negedge clk) begin
    if (valid2 && !vprev2) begin
      if (q2.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid2: got valid with data %0h expected none", data2);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("data2", data2, e.word);
        chk("latency2", cyc, e.cyc);
      end
    end
    vprev2 = valid2;
  end

  always @(negedge clk) begin
    if (valid1 && !vprev1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid1: got valid with data %0h expected none", data1);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("data1", data1, e.word);
        chk("latency1", cyc, e.cyc);
      end
    end
    vprev1 = valid1;
  end

  task automatic wait_valid(input int which);
    int n;
    n = 0;
    while (((which == 2) ? valid2 : valid1) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL timeout_valid%0d: got no valid expected valid within 200 cycles", which);
    end
  endtask

  task automatic handshake2();
    ready2 = 1'b1;
    @(negedge clk);
    ready2 = 1'b0;
    chk("valid2_after_hs", valid2, 0);
    chk("busy2_after_hs", busy2, 0);
  endtask

  task automatic start_scan2(input logic [7:0] word, output int c0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    c0 = cyc;
    q2.push_back('{word, c0 + 16});
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish before 20000 cycles");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    int c0;
    int n;

    // Reset held with start asserted
    start2 = 1'b1;
    start1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_valid", valid2, 0);
    chk("rst_data", data2, 8'h00);
    start2 = 1'b0;
    start1 = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_rst_busy", busy2, 0);
    chk("idle_after_rst_sel", sel2, 0);

    // Single scan, only a7 set, consumer not ready
    a2 = 8'h80;
    start_scan2(8'h80, c0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("sel_step_%0d", k), sel2, k / 2);
      chk($sformatf("busy_step_%0d", k), busy2, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", data2, 8'h80);
      chk("hold_valid", valid2, 1);
      @(negedge clk);
    end
    handshake2();
    chk("idle_sel", sel2, 0);

    // Pattern scan with a stray start mid-scan
    a2 = 8'h4D;
    start_scan2(8'h4D, c0);
    repeat (5) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_valid(2);
    chk("pattern_data_held", data2, 8'h4D);
    handshake2();
    repeat (20) @(negedge clk);
    chk("no_second_valid", valid2, 0);
    chk("no_second_busy", busy2, 0);

    // Back-to-back: start and ready held high
    a2 = 8'h4D;
    start2 = 1'b1;
    ready2 = 1'b1;
    @(negedge clk);
    c0 = cyc;
    q2.push_back('{8'h4D, c0 + 16});
    q2.push_back('{8'hFF, c0 + 33});
    wait_valid(2);
    a2 = 8'hFF;
    @(negedge clk);
    wait_valid(2);
    start2 = 1'b0;
    @(negedge clk);
    ready2 = 1'b0;
    chk("b2b_end_valid", valid2, 0);
    repeat (3) @(negedge clk);
    chk("b2b_end_busy", busy2, 0);

    // Reset in the middle of a scan at idx 5
    a2 = 8'h3C;
    start_scan2(8'h3C, c0);
    n = 0;
    while (sel2 != 3'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_idx5", sel2, 5);
    #1 rst_n = 1'b0;
    q2.delete();
    #1;
    chk("midrst_sel", sel2, 0);
    chk("midrst_busy", busy2, 0);
    chk("midrst_valid", valid2, 0);
    chk("midrst_data", data2, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a2 = 8'hC3;
    start_scan2(8'hC3, c0);
    wait_valid(2);
    handshake2();

    // SETTLE=1 instance
    a1 = 8'hA5;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    q1.push_back('{8'hA5, cyc + 8});
    chk("s1_busy", busy1, 1);
    wait_valid(1);
    ready1 = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    chk("s1_valid_after_hs", valid1, 0);

    repeat (3) @(negedge clk);
    chk("q2_drained", q2.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
